sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between three requesters: video fetch,
//  guest CPU and the SPI/SD image loader. Runs on the memory clock. Sits between the
//  guest core / loader and the SDRAM controller driving SDRAM_A/DQ/DQM/nRAS/nCAS/nWE.
//  Video has fixed top priority. CPU and loader alternate round-robin. A watchdog
//  aborts transfers the controller never acknowledges.
// PARAMETERS
//  AW       25   word address width
//  DW       16   data width; byte enables are DW/8 (maps to DQML/DQMH)
//  TIMEOUT  255  max cycles waiting for sdram_ack before abort; range 1..2**TW-1
//  TW       8    watchdog counter width
// PORTS
//  clk_ram       in   1       memory clock, only clock
//  reset         in   1       synchronous, active-high
//  vid_req       in   1       video request; level, held until vid_ack
//  vid_addr      in   AW      video address (read only)
//  vid_ack       out  1       1-cycle completion pulse
//  cpu_req       in   1       CPU request; level, held until cpu_ack
//  cpu_we        in   1       1=write 0=read
//  cpu_addr      in   AW      CPU address
//  cpu_wdata     in   DW      CPU write data
//  cpu_be        in   DW/8    CPU byte enables, active-high
//  cpu_ack       out  1       1-cycle completion pulse
//  ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_be/ldr_ack   loader port; same as cpu_*
//  rdata         out  DW      read data; valid in the ack cycle of the granted port
//  err           out  1       high with an ack when that transfer timed out
//  sdram_req     out  1       to controller; held until sdram_ack or abort
//  sdram_we      out  1       to controller
//  sdram_addr    out  AW      to controller
//  sdram_wdata   out  DW      to controller
//  sdram_be      out  DW/8    to controller
//  sdram_ack     in   1       1-cycle pulse from controller; read data valid same cycle
//  sdram_rdata   in   DW      controller read data
// BEHAVIOUR
//  Reset: state=IDLE. All acks, err, sdram_req and sdram_we are 0. rdata, sdram_addr,
//   sdram_wdata and sdram_be are 0. rr_last=LDR, so the CPU wins the first CPU/loader tie.
//  FSM states:
//   IDLE: sample requests and pick a winner.
//   BUSY: sdram_req=1.
//   DONE: pulse the winner's ack.
//  IDLE: winner is vid if vid_req. Else if cpu_req and ldr_req, grant the port that is
//   not rr_last. Else grant the single requester. On a grant, latch that port's command
//   into sdram_* registers, set sdram_req, clear the watchdog and go to BUSY.
//   No request: stay in IDLE.
//  Video grants force sdram_we=0 and sdram_be=all-ones.
//  BUSY: sdram_* are stable and the watchdog increments each cycle.
//   If sdram_ack: latch sdram_rdata into rdata, drop sdram_req, err=0, go to DONE.
//   Else if watchdog==TIMEOUT: drop sdram_req, rdata=0, err=1, go to DONE.
//   If sdram_ack and timeout occur in the same cycle, the ack wins (err=0).
//  DONE: exactly one cycle. Pulse the granted *_ack; err is valid alongside it.
//   If the grant was cpu or ldr, update rr_last. Then go to IDLE.
//  Latency: request sampled in IDLE, sdram_req high the next cycle, *_ack 1 cycle after
//   sdram_ack. Minimum 3 cycles from req to ack.
//  A requester drops req on the edge where it sees its ack, so IDLE never re-grants a
//   completed request. Between grants there is 1 idle cycle, which is the arbitration slot.
//  A request asserted while another port is in BUSY/DONE waits until the next IDLE.
//  Inputs of non-granted ports are ignored. Inputs of the granted port may change after
//   the grant, since the command is latched.
//  Video priority can starve the CPU/loader only while vid_req is high continuously.
//   This is accepted; the video fetcher bounds its own duty cycle.
//  Reset in BUSY: abort immediately to IDLE. sdram_req=0 on the next cycle, no ack is
//   issued, and any later sdram_ack is ignored in IDLE.
//  sdram_ack arriving in IDLE or DONE is ignored.
// STRUCTURE
//  Shared package sdram_arb_pkg: state encoding (IDLE/BUSY/DONE), port index constants
//   (P_VID=0, P_CPU=1, P_LDR=2), and the default AW/DW.
//  Sub-module sdram_arb_pick: combinational priority/round-robin selector.
//   Inputs: 3 reqs and rr_last. Output: one-hot grant.
//   It is unit-tested separately.
//  Everything else is one clocked process. No cross-clock logic inside this block.
// TESTING
//  1 Reset, then cpu_req read 0x000100, controller acks 4 cycles after sdram_req with
//    rdata 0xBEEF -> cpu_ack 1 cycle later, rdata=0xBEEF, err=0, vid_ack=ldr_ack=0.
//  2 vid_req, cpu_req and ldr_req all high in the same IDLE -> grant order vid, cpu, ldr.
//    vid sdram_we=0, sdram_be=2'b11.
//  3 cpu_req and ldr_req held continuously (re-raised after each ack) for 6 transfers ->
//    grants alternate cpu,ldr,cpu,ldr,cpu,ldr.
//  4 ldr write, addr 0x1FFFFFF, wdata 0x1234, be 2'b01, controller never acks ->
//    after TIMEOUT=255 cycles in BUSY, sdram_req drops and ldr_ack=1 with err=1.
//    Next request proceeds normally.
//  5 sdram_ack on the exact cycle watchdog==TIMEOUT -> ack with err=0 and the controller data.
//  6 reset asserted mid-BUSY on a cpu write -> sdram_req=0 next cycle, no cpu_ack.
//    A stray sdram_ack 2 cycles later produces no ack. A new cpu read completes normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM states, port indices, default widths.
package sdram_arb_pkg;

    localparam int unsigned DefAw = 25;
    localparam int unsigned DefDw = 16;

    // Bit positions of each requester inside request/grant vectors.
    localparam logic [1:0] P_VID = 2'd0;
    localparam logic [1:0] P_CPU = 2'd1;
    localparam logic [1:0] P_LDR = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller side signals of the SDRAM port arbiter.
interface sdram_port_arbiter_if #(
    parameter int unsigned AW = 25,
    parameter int unsigned DW = 16
);
    localparam int unsigned BW = DW / 8;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [BW-1:0] cpu_be;
    logic          cpu_ack;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [BW-1:0] ldr_be;
    logic          ldr_ack;

    logic [DW-1:0] rdata;
    logic          err;

    logic          sdram_req;
    logic          sdram_we;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_wdata;
    logic [BW-1:0] sdram_be;
    logic          sdram_ack;
    logic [DW-1:0] sdram_rdata;

    // Arbiter side.
    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be,
        input  sdram_ack, sdram_rdata,
        output vid_ack, cpu_ack, ldr_ack, rdata, err,
        output sdram_req, sdram_we, sdram_addr, sdram_wdata, sdram_be
    );

    // Requesters plus controller side.
    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be,
        output sdram_ack, sdram_rdata,
        input  vid_ack, cpu_ack, ldr_ack, rdata, err,
        input  sdram_req, sdram_we, sdram_addr, sdram_wdata, sdram_be
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: video first, then CPU/loader round-robin.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [2:0] req_i,          // indexed by P_VID/P_CPU/P_LDR
    input  logic       rr_last_ldr_i,  // 1: loader was served last among CPU/loader
    output logic [2:0] grant_o         // one-hot
);

    // Priority and tie-break decode.
    always_comb begin
        grant_o = '0;
        if (req_i[P_VID]) begin
            grant_o[P_VID] = 1'b1;
        end else if (req_i[P_CPU] && req_i[P_LDR]) begin
            if (rr_last_ldr_i) begin
                grant_o[P_CPU] = 1'b1;
            end else begin
                grant_o[P_LDR] = 1'b1;
            end
        end else if (req_i[P_CPU]) begin
            grant_o[P_CPU] = 1'b1;
        end else if (req_i[P_LDR]) begin
            grant_o[P_LDR] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among video, CPU and loader, with an ack watchdog.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input logic                 clk_ram,
    input logic                 reset,
    sdram_port_arbiter_if.slave bus
);

    localparam int unsigned   BW         = DW / 8;
    localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

    arb_state_e    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic          rr_last_ldr_q, rr_last_ldr_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] be_q, be_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [2:0]    req_vec;
    logic [2:0]    pick_grant;

    assign req_vec = {bus.ldr_req, bus.cpu_req, bus.vid_req};

    sdram_arb_pick u_pick (
        .req_i        (req_vec),
        .rr_last_ldr_i(rr_last_ldr_q),
        .grant_o      (pick_grant)
    );

    // Next-state: arbitration in idle, watchdog and completion in busy, ack slot in done.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_last_ldr_d = rr_last_ldr_q;
        wdog_d        = wdog_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        unique case (state_q)
            StIdle: begin
                if (|pick_grant) begin
                    grant_d = pick_grant;
                    state_d = StBusy;
                    req_d   = 1'b1;
                    wdog_d  = '0;
                    err_d   = 1'b0;
                    if (pick_grant[P_VID]) begin
                        // Video is read-only and always fetches whole words.
                        we_d    = 1'b0;
                        addr_d  = bus.vid_addr;
                        wdata_d = '0;
                        be_d    = '1;
                    end else if (pick_grant[P_CPU]) begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        be_d    = bus.cpu_be;
                    end else begin
                        we_d    = bus.ldr_we;
                        addr_d  = bus.ldr_addr;
                        wdata_d = bus.ldr_wdata;
                        be_d    = bus.ldr_be;
                    end
                end
            end
            StBusy: begin
                wdog_d = wdog_q + 1'b1;
                // An ack coinciding with the timeout still counts as success.
                if (bus.sdram_ack) begin
                    rdata_d = bus.sdram_rdata;
                    req_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (wdog_q == TimeoutCnt) begin
                    rdata_d = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
                if (grant_q[P_CPU]) begin
                    rr_last_ldr_d = 1'b0;
                end else if (grant_q[P_LDR]) begin
                    rr_last_ldr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any transfer in flight.
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            rr_last_ldr_q <= 1'b1;
            wdog_q        <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_last_ldr_q <= rr_last_ldr_d;
            wdog_q        <= wdog_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign bus.vid_ack     = (state_q == StDone) && grant_q[P_VID];
    assign bus.cpu_ack     = (state_q == StDone) && grant_q[P_CPU];
    assign bus.ldr_ack     = (state_q == StDone) && grant_q[P_LDR];
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;
    assign bus.sdram_req   = req_q;
    assign bus.sdram_we    = we_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_wdata = wdata_q;
    assign bus.sdram_be    = be_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table plus timeout/reset sequences.
module tb_sdram_port_arbiter;

    localparam logic [24:0] VidAddr  = 25'h00ABCDE;
    localparam logic [24:0] CpuAddr  = 25'h0000100;
    localparam logic [24:0] LdrAddr  = 25'h1FFFFFF;
    localparam logic [15:0] CpuWdata = 16'hC0DE;
    localparam logic [15:0] LdrWdata = 16'h1234;
    localparam logic [1:0]  CpuBe    = 2'b10;
    localparam logic [1:0]  LdrBe    = 2'b01;

    // req/exp_ack bit order: {vid, cpu, ldr}
    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        cwe;
        logic        lwe;
        int          lat;
        logic [15:0] rd;
        logic [2:0]  exp_ack;
        logic        exp_we;
        logic [24:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sdram_port_arbiter_if #(.AW(25), .DW(16)) bus ();

    sdram_port_arbiter #(
        .AW(25), .DW(16), .TIMEOUT(255), .TW(8)
    ) dut (
        .clk_ram(clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] acks();
        return {29'd0, bus.vid_ack, bus.cpu_ack, bus.ldr_ack};
    endfunction

    // One complete transfer: present requests, controller acks after v.lat busy cycles.
    task automatic run_vec(input string tag, input vec_t v);
        if (v.rst) begin
            bus.vid_req = 1'b0;
            bus.cpu_req = 1'b0;
            bus.ldr_req = 1'b0;
            reset = 1'b1;
            step();
            reset = 1'b0;
        end
        bus.vid_req = v.req[2];
        bus.cpu_req = v.req[1];
        bus.ldr_req = v.req[0];
        bus.cpu_we  = v.cwe;
        bus.ldr_we  = v.lwe;
        step();
        check({tag, " sdram_req"}, 32'(bus.sdram_req), 32'd1);
        check({tag, " sdram_addr"}, 32'(bus.sdram_addr), 32'(v.exp_addr));
        check({tag, " sdram_we"}, 32'(bus.sdram_we), 32'(v.exp_we));
        check({tag, " sdram_be"}, 32'(bus.sdram_be), 32'(v.exp_be));
        if (v.exp_we) check({tag, " sdram_wdata"}, 32'(bus.sdram_wdata), 32'(v.exp_wdata));
        check({tag, " no early ack"}, acks(), 32'd0);
        repeat (v.lat) step();
        bus.sdram_ack   = 1'b1;
        bus.sdram_rdata = v.rd;
        step();
        bus.sdram_ack   = 1'b0;
        bus.sdram_rdata = 16'h0;
        check({tag, " ack"}, acks(), 32'(v.exp_ack));
        check({tag, " rdata"}, 32'(bus.rdata), 32'(v.rd));
        check({tag, " err"}, 32'(bus.err), 32'd0);
        check({tag, " req dropped"}, 32'(bus.sdram_req), 32'd0);
        if (v.exp_ack[2]) bus.vid_req = 1'b0;
        if (v.exp_ack[1]) bus.cpu_req = 1'b0;
        if (v.exp_ack[0]) bus.ldr_req = 1'b0;
        step();
        check({tag, " ack one cycle"}, acks(), 32'd0);
    endtask

    vec_t vecs[10];
    vec_t v;
    int   cnt;

    initial begin
        // rst req  cwe  lwe  lat rd       ack     we   addr     be     wdata
        vecs[0] = '{1'b1, 3'b010, 1'b0, 1'b0, 4, 16'hBEEF, 3'b010, 1'b0, CpuAddr, CpuBe, 16'h0};
        vecs[1] = '{1'b1, 3'b111, 1'b1, 1'b1, 2, 16'h1111, 3'b100, 1'b0, VidAddr, 2'b11, 16'h0};
        vecs[2] = '{1'b0, 3'b011, 1'b1, 1'b1, 1, 16'h2222, 3'b010, 1'b1, CpuAddr, CpuBe, CpuWdata};
        vecs[3] = '{1'b0, 3'b001, 1'b1, 1'b1, 0, 16'h3333, 3'b001, 1'b1, LdrAddr, LdrBe, LdrWdata};
        vecs[4] = '{1'b0, 3'b011, 1'b0, 1'b1, 3, 16'h4444, 3'b010, 1'b0, CpuAddr, CpuBe, 16'h0};
        vecs[5] = '{1'b0, 3'b011, 1'b0, 1'b1, 1, 16'h5555, 3'b001, 1'b1, LdrAddr, LdrBe, LdrWdata};
        vecs[6] = '{1'b0, 3'b011, 1'b1, 1'b0, 0, 16'h6666, 3'b010, 1'b1, CpuAddr, CpuBe, CpuWdata};
        vecs[7] = '{1'b0, 3'b011, 1'b1, 1'b0, 2, 16'h7777, 3'b001, 1'b0, LdrAddr, LdrBe, 16'h0};
        vecs[8] = '{1'b0, 3'b011, 1'b0, 1'b0, 1, 16'h8888, 3'b010, 1'b0, CpuAddr, CpuBe, 16'h0};
        vecs[9] = '{1'b0, 3'b011, 1'b0, 1'b1, 5, 16'h9999, 3'b001, 1'b1, LdrAddr, LdrBe, LdrWdata};

        reset           = 1'b1;
        bus.vid_req     = 1'b0;
        bus.vid_addr    = VidAddr;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = CpuAddr;
        bus.cpu_wdata   = CpuWdata;
        bus.cpu_be      = CpuBe;
        bus.ldr_req     = 1'b0;
        bus.ldr_we      = 1'b0;
        bus.ldr_addr    = LdrAddr;
        bus.ldr_wdata   = LdrWdata;
        bus.ldr_be      = LdrBe;
        bus.sdram_ack   = 1'b0;
        bus.sdram_rdata = 16'h0;

        // Reset state.
        repeat (2) step();
        check("rst acks", acks(), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        check("rst sdram_req", 32'(bus.sdram_req), 32'd0);
        check("rst sdram_we", 32'(bus.sdram_we), 32'd0);
        check("rst rdata", 32'(bus.rdata), 32'd0);
        check("rst sdram_addr", 32'(bus.sdram_addr), 32'd0);
        check("rst sdram_wdata", 32'(bus.sdram_wdata), 32'd0);
        check("rst sdram_be", 32'(bus.sdram_be), 32'd0);
        reset = 1'b0;
        step();
        check("idle no req", 32'(bus.sdram_req), 32'd0);

        // Table: single CPU read, priority order, then round-robin alternation.
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        bus.ldr_req = 1'b0;
        step();

        // Loader write that the controller never acks: busy for TIMEOUT+1 cycles.
        bus.ldr_req = 1'b1;
        bus.ldr_we  = 1'b1;
        step();
        check("to sdram_we", 32'(bus.sdram_we), 32'd1);
        check("to sdram_addr", 32'(bus.sdram_addr), 32'(LdrAddr));
        check("to sdram_wdata", 32'(bus.sdram_wdata), 32'(LdrWdata));
        check("to sdram_be", 32'(bus.sdram_be), 32'(LdrBe));
        cnt = 0;
        while (bus.sdram_req === 1'b1 && cnt < 400) begin
            cnt++;
            step();
        end
        check("to busy cycles", 32'(cnt), 32'd256);
        check("to ack", acks(), 32'b001);
        check("to err", 32'(bus.err), 32'd1);
        check("to rdata", 32'(bus.rdata), 32'd0);
        bus.ldr_req = 1'b0;
        step();
        check("to err cleared", 32'(bus.err), 32'd0);
        check("to ack one cycle", acks(), 32'd0);

        // Next request after the abort proceeds normally.
        v = '{1'b0, 3'b010, 1'b0, 1'b0, 1, 16'hA5A5, 3'b010, 1'b0, CpuAddr, CpuBe, 16'h0};
        run_vec("after to", v);

        // Ack in the same cycle the watchdog reaches TIMEOUT: ack wins.
        v = '{1'b0, 3'b001, 1'b0, 1'b0, 255, 16'h5A5A, 3'b001, 1'b0, LdrAddr, LdrBe, 16'h0};
        run_vec("ack at to", v);

        // Reset in the middle of a CPU write.
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        step();
        step();
        check("mid req busy", 32'(bus.sdram_req), 32'd1);
        check("mid we", 32'(bus.sdram_we), 32'd1);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        step();
        reset = 1'b0;
        check("mid req aborted", 32'(bus.sdram_req), 32'd0);
        check("mid no ack", acks(), 32'd0);
        step();
        bus.sdram_ack   = 1'b1;
        bus.sdram_rdata = 16'hDEAD;
        step();
        bus.sdram_ack   = 1'b0;
        bus.sdram_rdata = 16'h0;
        check("stray ack ignored", acks(), 32'd0);
        check("stray req", 32'(bus.sdram_req), 32'd0);
        step();
        check("stray ack later", acks(), 32'd0);
        check("stray rdata", 32'(bus.rdata), 32'd0);
        v = '{1'b0, 3'b010, 1'b0, 1'b0, 2, 16'h0F0F, 3'b010, 1'b0, CpuAddr, CpuBe, 16'h0};
        run_vec("after rst", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
